// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared constants for scan_mux
package scan_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int STALL_W = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker, first set request at or after base
module rr_pick #(
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] base,
  output logic            found,
  output logic [SELW-1:0] idx
);
  // walk farthest-to-nearest so the nearest requester wins the last write
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (req[(int'(base) + k) % NCH]) begin
        found = 1'b1;
        idx = SELW'((int'(base) + k) % NCH);
      end
  end
endmodule

// File: rtl/scan_mux.sv
// scan_mux: N:1 registered mux, fixed-select or round-robin scan with valid/ready
// SCAN_MUX_STALL_CNT_EN adds a saturating stall_cnt output
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
`ifdef SCAN_MUX_STALL_CNT_EN
  input  logic                 out_ready,
  output logic [STALL_W-1:0]   stall_cnt
`else
  input  logic                 out_ready
`endif
);
  logic [SELW-1:0] rr_ptr, rr_idx, chosen;
  logic rr_found, have, can_load, xfer_in;
  rr_pick #(.NCH(NCH)) u_pick (.req(in_valid), .base(rr_ptr), .found(rr_found), .idx(rr_idx));
  always_comb begin
    can_load = !out_valid | out_ready;
    chosen = (mode == MODE_RR) ? rr_idx : sel;
    have = (mode == MODE_RR) ? rr_found : (int'(sel) < NCH);
    in_ready = (can_load & have) ? (NCH'(1) << chosen) : '0;
    xfer_in = have & can_load & in_valid[chosen];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      rr_ptr <= '0;
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data <= in_data[int'(chosen)*WIDTH +: WIDTH];
        out_ch <= chosen;
      end else if (out_ready) out_valid <= 1'b0;
      if (xfer_in && mode == MODE_RR) rr_ptr <= (int'(chosen) == NCH - 1) ? '0 : chosen + 1'b1;
    end
`ifdef SCAN_MUX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed self-checking bench for scan_mux (NCH=4 and NCH=5 instances)
module tb_scan_mux;
  logic clk = 1'b0, rst_n;
  logic mode, out_ready, out_valid;
  logic [1:0] sel, out_ch;
  logic [31:0] in_data;
  logic [3:0] in_valid, in_ready;
  logic [7:0] out_data;
  logic mode5, out_ready5, out_valid5;
  logic [2:0] sel5, out_ch5;
  logic [39:0] in_data5;
  logic [4:0] in_valid5, in_ready5;
  logic [7:0] out_data5;
  logic [31:0] rr_data;
  int n_vec = 0, n_err = 0;
`ifdef SCAN_MUX_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt5;
`endif
  always #5 clk = ~clk;
  scan_mux #(.NCH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
`ifdef SCAN_MUX_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_valid(out_valid), .out_ready(out_ready));
  scan_mux #(.NCH(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .in_data(in_data5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5), .out_ch(out_ch5),
`ifdef SCAN_MUX_STALL_CNT_EN
    .stall_cnt(stall_cnt5),
`endif
    .out_valid(out_valid5), .out_ready(out_ready5));

  task automatic test_reset;
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    mode5 = 1'b0; sel5 = 3'd0; in_data5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
    #12;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== 11'd0) begin
      n_err++; $display("FAIL reset_state got v=%b ch=%0d d=%h need 0", out_valid, out_ch, out_data);
    end
    n_vec++;
    if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got %b need 0000", in_ready); end
`ifdef SCAN_MUX_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d need 0", stall_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1; mode = 1'b0; sel = 2'd1; in_data = 32'h0000_3C00; in_valid = 4'b0010;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h3C}) begin
      n_err++; $display("FAIL pre_reset_load got v=%b ch=%0d d=%h need v=1 ch=1 d=3c", out_valid, out_ch, out_data);
    end
    in_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== 11'd0) begin
      n_err++; $display("FAIL async_reset got v=%b ch=%0d d=%h need 0", out_valid, out_ch, out_data);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_fixed;
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; in_data = {8'h44, 8'hA5, 8'h22, 8'h11}; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready got %b need 0100", in_ready); end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
      n_err++; $display("FAIL fixed_load got v=%b ch=%0d d=%h need v=1 ch=2 d=a5", out_valid, out_ch, out_data);
    end
    in_valid = '0;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b0, 2'd2, 8'hA5}) begin
      n_err++; $display("FAIL fixed_drain got v=%b ch=%0d d=%h need v=0 ch=2 d=a5", out_valid, out_ch, out_data);
    end
    n_vec++;
    if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_ready_no_valid got %b need 0100", in_ready); end
    @(negedge clk);
    sel5 = 3'd5; in_valid5 = 5'b11111; in_data5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    n_vec++;
    if (in_ready5 !== 5'b00000) begin n_err++; $display("FAIL sel_out_of_range got %b need 00000", in_ready5); end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL sel_oor_no_load got v=%b need 0", out_valid5); end
    @(negedge clk);
    sel5 = 3'd4;
    #1;
    n_vec++;
    if (in_ready5 !== 5'b10000) begin n_err++; $display("FAIL sel_last_ready got %b need 10000", in_ready5); end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid5, out_ch5, out_data5} !== {1'b1, 3'd4, 8'h55}) begin
      n_err++; $display("FAIL sel_last_load got v=%b ch=%0d d=%h need v=1 ch=4 d=55", out_valid5, out_ch5, out_data5);
    end
    in_valid5 = '0;
  endtask

  task automatic test_round_robin;
    @(negedge clk);
    rr_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    mode = 1'b1; in_data = rr_data; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'(i % 4), rr_data[(i % 4)*8 +: 8]}) begin
        n_err++; $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h need ch=%0d", i, out_valid, out_ch, out_data, i % 4);
      end
    end
    @(negedge clk) in_valid = '0;
  endtask

  task automatic test_rr_skip;
    @(negedge clk) in_valid = 4'b0001;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hA0}) begin
      n_err++; $display("FAIL skip_setup got v=%b ch=%0d d=%h need ch=0 d=a0", out_valid, out_ch, out_data);
    end
    @(negedge clk) in_valid = 4'b1001;
    #1;
    n_vec++;
    if (in_ready !== 4'b1000) begin n_err++; $display("FAIL skip_ready got %b need 1000", in_ready); end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'hD3}) begin
      n_err++; $display("FAIL skip_first got v=%b ch=%0d d=%h need ch=3 d=d3", out_valid, out_ch, out_data);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hA0}) begin
      n_err++; $display("FAIL skip_wrap got v=%b ch=%0d d=%h need ch=0 d=a0", out_valid, out_ch, out_data);
    end
    @(negedge clk) in_valid = 4'b0011;
    #1;
    n_vec++;
    if (in_ready !== 4'b0010) begin n_err++; $display("FAIL skip_ptr_after got %b need 0010", in_ready); end
    in_valid = '0;
  endtask

  task automatic test_backpressure;
    @(negedge clk) begin in_valid = 4'b0100; out_ready = 1'b1; end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hC2}) begin
      n_err++; $display("FAIL bp_load got v=%b ch=%0d d=%h need ch=2 d=c2", out_valid, out_ch, out_data);
    end
    @(negedge clk) begin out_ready = 1'b0; in_valid = 4'b0010; end
    #1;
    n_vec++;
    if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_low got %b need 0000", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, out_ch, out_data, in_ready} !== {1'b1, 2'd2, 8'hC2, 4'b0000}) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h rdy=%b need ch=2 d=c2 rdy=0000", i, out_valid, out_ch, out_data, in_ready);
      end
    end
`ifdef SCAN_MUX_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL bp_stall_cnt got %0d need 5", stall_cnt); end
`endif
    @(negedge clk) out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready got %b need 0010", in_ready); end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'hB1}) begin
      n_err++; $display("FAIL bp_drain_load got v=%b ch=%0d d=%h need ch=1 d=b1", out_valid, out_ch, out_data);
    end
    @(negedge clk) in_valid = '0;
  endtask

  task automatic test_mode_switch;
    @(negedge clk) begin in_valid = 4'b1000; out_ready = 1'b0; end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'hD3}) begin
      n_err++; $display("FAIL ms_load got v=%b ch=%0d d=%h need ch=3 d=d3", out_valid, out_ch, out_data);
    end
    @(negedge clk) begin mode = 1'b0; sel = 2'd2; in_valid = 4'b0101; end
    #1;
    n_vec++;
    if (in_ready !== 4'b0000) begin n_err++; $display("FAIL ms_stall_ready got %b need 0000", in_ready); end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'hD3}) begin
      n_err++; $display("FAIL ms_held got v=%b ch=%0d d=%h need ch=3 d=d3", out_valid, out_ch, out_data);
    end
    @(negedge clk) out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 4'b0100) begin n_err++; $display("FAIL ms_sel_ready got %b need 0100", in_ready); end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hC2}) begin
      n_err++; $display("FAIL ms_next got v=%b ch=%0d d=%h need ch=2 d=c2", out_valid, out_ch, out_data);
    end
    in_valid = '0;
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_round_robin;
    test_rr_skip;
    test_backpressure;
    test_mode_switch;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised N-to-1 channel multiplexer, successor to the fixed 4:1 gate-level mux.
- Adds a registered output stage with valid/ready handshakes on every input and on the output.
- Two selection modes: fixed-select (software picks the channel) and round-robin scan (fair rotation over the valid channels).
- Sits between multiple producers and one consumer in the simulator's sequential test circuits.

Parameters:
- NCH, 4, number of input channels (>=2).
- WIDTH, 8, data bits per channel.
- SELW (localparam), $clog2(NCH), select/channel-index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin scan.
- sel  input  SELW  channel index used in fixed mode.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- One clock domain, clk. Reset rst_n is asynchronous, active-low: assertion immediately clears all state; deassertion is synchronous to clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is 0 because no valid can be chosen.
- can_load = !out_valid | out_ready.
- Fixed mode:
  - chosen = sel.
  - If sel >= NCH, nothing is chosen and all in_ready are 0.
- Round-robin mode:
  - chosen = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, …, NCH-1, then 0, …, rr_ptr-1.
  - If no channel is valid, nothing is chosen.
- in_ready[i] = can_load & (i == chosen). At most one bit is set. in_ready does not depend on in_valid[chosen] in fixed mode; in round-robin mode the chosen channel is valid by construction.
- Transfer in: in_valid[chosen] & in_ready[chosen]. Next edge: out_data <= chosen data, out_ch <= chosen, out_valid <= 1.
- Round-robin pointer: on a transfer in, rr_ptr <= (chosen==NCH-1) ? 0 : chosen+1. Otherwise rr_ptr holds. rr_ptr is updated only in mode 1.
- Transfer out: out_valid & out_ready. With no simultaneous transfer in, out_valid <= 0 and out_data/out_ch hold their last value.
- Simultaneous out-drain and in-load in the same cycle: the new word replaces the old; out_valid stays 1. This gives full throughput of 1 word/cycle.
- Latency: 1 cycle from input handshake to out_valid.
- Stall: while out_valid & !out_ready, out_data/out_ch are stable and all in_ready=0.
- Changes to mode or sel never alter a word already held; they affect only the next selection. A mode change does not reset rr_ptr.
- Reset asserted mid-transfer drops the held word; no output handshake completes after reset assertion.

Optional Feature:
- Macro SCAN_MUX_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Counts cycles with out_valid & !out_ready; saturates at 16'hFFFF.
  - Reset value 0. Cleared on reset only.
- Undefined: no port, no counter logic.

Decomposition:
- Package scan_mux_pkg: constants MODE_FIXED=1'b0 and MODE_RR=1'b1, plus a stall-count width constant of 16.
- Sub-module rr_pick (NCH): combinational rotating-priority picker.
  - Inputs: request vector, base pointer.
  - Outputs: found flag, chosen index.
  - Instantiated once; used only in round-robin mode.

Test Plan:
- Reset: assert rst_n=0 mid-stream while out_valid=1 -> out_valid, out_data and out_ch drop to 0 immediately, without waiting for a clock edge.
- Fixed mode: NCH=4, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2, out_valid=1. Repeat with sel=5 (NCH=5, SELW=3) -> in_ready=0.
- Round-robin mode: all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one word every cycle.
- Round-robin skip: in_valid=4'b1001, rr_ptr=1 -> ch3 chosen first, then ch0; rr_ptr=1 after ch0.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0. With the macro defined, stall_cnt=5. Then release out_ready with ch1 valid -> drain and load in the same cycle.
- Mode switch: change mode 1->0 while holding a word -> held word unchanged; next load follows sel.
